// File: rtl/mc_core_pkg.sv
// Shared types and constants for the multi-cycle 9-bit-ISA core.
package mc_core_pkg;

  localparam int unsigned REG_N  = 8;
  localparam int unsigned REG_AW = 3;
  localparam logic [8:0]  HALT_INSN = 9'h1FF;

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpAnd  = 3'd2,
    OpAddi = 3'd3,
    OpLd   = 3'd4,
    OpSt   = 3'd5,
    OpBnz  = 3'd6,
    OpJmp  = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StMem,
    StHalt
  } state_e;

endpackage

// File: rtl/mc_core_regfile.sv
// 8-entry register file: two asynchronous read ports, one synchronous write port.
module mc_core_regfile
  import mc_core_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_q [REG_N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/mc_core.sv
// Multi-cycle core for the 9-bit ISA: FETCH/EXEC/MEM sequencer with handshaked instruction
// and data ports and a saturating retired-instruction counter.
module mc_core
  import mc_core_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [8:0]        imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  instr_count
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [8:0]        ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;

  opcode_e           op;
  logic [2:0]        field_a, field_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic [DATA_W-1:0] alu_res;
  logic [PC_W-1:0]   pc_inc, pc_branch, pc_jump;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic              retire;

  assign op      = opcode_e'(ir_q[8:6]);
  assign field_a = ir_q[5:3];
  assign field_b = ir_q[2:0];

  mc_core_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (field_a),
    .rdata_a (rdata_a),
    .raddr_b (field_b),
    .rdata_b (rdata_b),
    .we      (rf_we),
    .waddr   (field_a),
    .wdata   (rf_wdata)
  );

  always_comb begin
    unique case (op)
      OpAdd:   alu_res = rdata_a + rdata_b;
      OpSub:   alu_res = rdata_a - rdata_b;
      OpAnd:   alu_res = rdata_a & rdata_b;
      default: alu_res = rdata_a + DATA_W'(field_b);
    endcase
  end

  assign pc_inc    = pc_q + PC_W'(1);
  assign pc_branch = pc_q + {{(PC_W-3){field_b[2]}}, field_b};
  assign pc_jump   = PC_W'(ir_q[5:0]);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    cnt_d        = cnt_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    rf_we        = 1'b0;
    rf_wdata     = alu_res;
    retire       = 1'b0;

    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      StFetch: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = StExec;
        end
      end
      StExec: begin
        if (ir_q == HALT_INSN) begin
          state_d = StHalt;
        end else begin
          state_d = StFetch;
          unique case (op)
            OpAdd, OpSub, OpAnd, OpAddi: begin
              rf_we  = 1'b1;
              pc_d   = pc_inc;
              retire = 1'b1;
            end
            OpLd, OpSt: begin
              // Address and store data are captured here so they stay stable through MEM.
              dmem_we_d    = (op == OpSt);
              dmem_addr_d  = rdata_b;
              dmem_wdata_d = rdata_a;
              state_d      = StMem;
            end
            OpBnz: begin
              pc_d   = (rdata_a != '0) ? pc_branch : pc_inc;
              retire = 1'b1;
            end
            OpJmp: begin
              pc_d   = pc_jump;
              retire = 1'b1;
            end
          endcase
        end
      end
      StMem: begin
        if (dmem_ack) begin
          rf_we    = !dmem_we_q;
          rf_wdata = dmem_rdata;
          pc_d     = pc_inc;
          retire   = 1'b1;
          state_d  = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    if (retire && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      ir_q         <= '0;
      cnt_q        <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      cnt_q        <= cnt_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  // Requests decode straight from state so an asynchronous reset drops them at once.
  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign dmem_req    = (state_q == StMem);
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign busy        = (state_q == StFetch) || (state_q == StExec) || (state_q == StMem);
  assign done        = (state_q == StHalt);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_core.sv
// Self-checking bench for mc_core: directed vectors, corner sequences and random programs
// checked against an instruction-level model of the ISA.
module tb_mc_core;

  localparam int DATA_W = 8;
  localparam int PC_W   = 6;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [8:0] HALT_W = 9'h1FF;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [8:0]        imem_data;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  instr_count;

  mc_core #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .busy        (busy),
    .done        (done),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [8:0] imem [64];
  logic [7:0] dmem [256];
  logic [7:0] m_dmem [256];
  logic [7:0] m_r [8];
  int         m_cnt;

  typedef struct {
    string      name;
    logic [8:0] insn;
    logic [7:0] a_val;
    logic [7:0] b_val;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [8:0] enc(input int op, input int a, input int b);
    return {op[2:0], a[2:0], b[2:0]};
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < 64; i++) imem[i] = HALT_W;
  endtask

  task automatic set_mem(input int addr, input logic [7:0] val);
    dmem[addr]   = val;
    m_dmem[addr] = val;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
  endtask

  // Runs imem from PC 0, acting as both memories with random waits, and follows the
  // program with an instruction-level model that decides what the DUT must do each cycle.
  task automatic run_prog(input int max_iw, input int max_dw, input int fixed_dw,
                          input bit poke, output int ncyc);
    logic [5:0] m_pc;
    logic [8:0] w;
    logic [2:0] op, a, b;
    logic [7:0] ea, ed;
    int wt, steps, c0, ndiff;
    bit halted;
    m_pc = '0;
    m_cnt = 0;
    halted = 1'b0;
    steps = 0;
    c0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!halted && steps < 200) begin
      steps++;
      wt = $urandom_range(max_iw, 0);
      for (int i = 0; i < wt; i++) begin
        start = poke;
        dmem_ack = 1'($urandom_range(1, 0));
        dmem_rdata = 8'($urandom);
        tick();
      end
      start = 1'b0;
      dmem_ack = 1'b0;
      chk("fetch", {imem_req, busy, done, imem_addr}, {1'b1, 1'b1, 1'b0, m_pc});
      w = imem[m_pc];
      imem_ack = 1'b1;
      imem_data = imem[imem_addr];
      tick();
      imem_ack = 1'b0;
      imem_data = 9'($urandom);
      tick();
      op = w[8:6];
      a = w[5:3];
      b = w[2:0];
      if (w == HALT_W) begin
        halted = 1'b1;
      end else begin
        case (op)
          3'd0: begin m_r[a] = m_r[a] + m_r[b]; m_pc = m_pc + 6'd1; end
          3'd1: begin m_r[a] = m_r[a] - m_r[b]; m_pc = m_pc + 6'd1; end
          3'd2: begin m_r[a] = m_r[a] & m_r[b]; m_pc = m_pc + 6'd1; end
          3'd3: begin m_r[a] = m_r[a] + {5'd0, b}; m_pc = m_pc + 6'd1; end
          3'd4, 3'd5: begin
            ea = m_r[b];
            ed = (op == 3'd5) ? m_r[a] : 8'h00;
            wt = (fixed_dw >= 0) ? fixed_dw : $urandom_range(max_dw, 0);
            for (int i = 0; i < wt; i++) begin
              chk("dmem_hold", {dmem_req, busy}, 2'b11);
              start = poke;
              imem_ack = 1'($urandom_range(1, 0));
              imem_data = 9'($urandom);
              tick();
            end
            start = 1'b0;
            imem_ack = 1'b0;
            chk("dmem", {dmem_req, dmem_we, dmem_addr, dmem_we ? dmem_wdata : 8'h00},
                {1'b1, (op == 3'd5), ea, ed});
            dmem_ack = 1'b1;
            dmem_rdata = dmem[dmem_addr];
            if (dmem_req && dmem_we) dmem[dmem_addr] = dmem_wdata;
            tick();
            dmem_ack = 1'b0;
            dmem_rdata = 8'($urandom);
            if (op == 3'd4) m_r[a] = m_dmem[ea];
            else m_dmem[ea] = ed;
            m_pc = m_pc + 6'd1;
          end
          3'd6: m_pc = (m_r[a] != 8'h00) ? m_pc + {{3{b[2]}}, b} : m_pc + 6'd1;
          default: m_pc = w[5:0];
        endcase
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
    if (!halted) begin
      n_err++;
      $display("FAIL model_budget: program did not reach HALT within 200 steps");
    end
    chk("halt_state", {done, busy, imem_req, dmem_req}, 4'b1000);
    chk("instr_count", instr_count, m_cnt[CNT_W-1:0]);
    ndiff = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== m_dmem[i]) ndiff++;
    chk("dmem_image", ndiff, 0);
    ncyc = cyc - c0;
  endtask

  task automatic gen_prog();
    int len, op;
    fill_halt();
    len = $urandom_range(24, 8);
    for (int pc = 0; pc < len; pc++) begin
      op = $urandom_range(7, 0);
      if (op == 6) imem[pc] = enc(6, $urandom_range(7, 0), $urandom_range(3, 1));
      else if (op == 7) imem[pc] = {3'd7, 6'($urandom_range(len, pc + 1))};
      else imem[pc] = enc(op, $urandom_range(7, 0), $urandom_range(7, 0));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nc;
    reset = 1'b1;
    start = 1'b0;
    imem_ack = 1'b0;
    imem_data = '0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    for (int i = 0; i < 256; i++) set_mem(i, 8'($urandom));
    tick();
    chk("reset_outs", {imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, busy,
                       done, instr_count}, 0);
    tick();
    reset = 1'b0;

    vecs[0] = '{"add",      enc(0, 1, 2), 8'h12, 8'h34, 8'h46};
    vecs[1] = '{"sub_wrap", enc(1, 1, 2), 8'h00, 8'h01, 8'hFF};
    vecs[2] = '{"and",      enc(2, 1, 2), 8'hF0, 8'h3C, 8'h30};
    vecs[3] = '{"addi_7",   enc(3, 1, 7), 8'hFE, 8'h55, 8'h05};
    vecs[4] = '{"add_wrap", enc(0, 1, 2), 8'hFF, 8'h01, 8'h00};
    vecs[5] = '{"sub",      enc(1, 1, 2), 8'h80, 8'h01, 8'h7F};
    vecs[6] = '{"addi_0",   enc(3, 1, 0), 8'h10, 8'h99, 8'h10};
    for (int v = 0; v < 7; v++) begin
      do_reset();
      fill_halt();
      imem[0] = enc(4, 1, 0);  // LD r1,[r0]
      imem[1] = enc(3, 3, 1);  // ADDI r3,1
      imem[2] = enc(4, 2, 3);  // LD r2,[r3]
      imem[3] = vecs[v].insn;
      imem[4] = enc(3, 3, 1);
      imem[5] = enc(5, 1, 3);  // ST r1,[r3]
      set_mem(0, vecs[v].a_val);
      set_mem(1, vecs[v].b_val);
      run_prog(2, 2, -1, 1'b0, nc);
      chk(vecs[v].name, dmem[2], vecs[v].exp);
    end

    // ADDI/ADDI/ADD with zero waits, then restart from HALT keeping registers.
    do_reset();
    fill_halt();
    imem[0] = enc(3, 1, 5);
    imem[1] = enc(3, 1, 3);
    imem[2] = enc(0, 2, 1);
    run_prog(0, 0, -1, 1'b0, nc);
    chk("t1_cycles", nc, 9);
    chk("t1_count", instr_count, 3);
    fill_halt();
    imem[0] = enc(5, 1, 0);
    imem[1] = enc(3, 0, 1);
    imem[2] = enc(5, 2, 0);
    run_prog(1, 1, -1, 1'b0, nc);
    chk("t1_r1", dmem[0], 8'h08);
    chk("t1_r2", dmem[1], 8'h08);

    // Reset while a fetch is waiting for its ack.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_reset_req", {imem_req, busy}, 2'b11);
    reset = 1'b1;
    #1;
    chk("reset_mid", {imem_req, dmem_req, busy, done, instr_count}, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    set_mem(0, 8'hAA);
    set_mem(1, 8'hAA);
    run_prog(1, 1, -1, 1'b0, nc);
    chk("reset_r1", dmem[0], 8'h00);
    chk("reset_r2", dmem[1], 8'h00);

    // Store then load with a slow data port; start pulses while busy must be ignored.
    do_reset();
    fill_halt();
    imem[0] = enc(3, 3, 2);
    imem[1] = enc(3, 4, 7);
    imem[2] = enc(5, 4, 3);
    imem[3] = enc(4, 5, 3);
    imem[4] = enc(3, 3, 1);
    imem[5] = enc(5, 5, 3);
    run_prog(2, 0, 3, 1'b1, nc);
    chk("t2_st", dmem[2], 8'h07);
    chk("t2_ld", dmem[3], 8'h07);

    // Counted loop with BNZ -2; the second variant overflows the 4-bit counter.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      fill_halt();
      imem[0] = enc(3, 1, (k == 0) ? 3 : 7);
      imem[1] = enc(3, 6, 1);
      imem[2] = enc(3, 2, 1);
      imem[3] = enc(1, 1, 6);
      imem[4] = enc(6, 1, 6);
      imem[5] = enc(5, 2, 0);
      imem[6] = enc(3, 0, 1);
      imem[7] = enc(5, 1, 0);
      run_prog(1, 1, -1, 1'b0, nc);
      chk("loop_r2", dmem[0], (k == 0) ? 8'h03 : 8'h07);
      chk("loop_r1", dmem[1], 8'h00);
      chk("loop_count", instr_count, (k == 0) ? 14 : CNT_MAX);
    end

    // JMP to 62, HALT at 63.
    fill_halt();
    imem[0] = {3'd7, 6'd62};
    imem[62] = enc(3, 0, 1);
    run_prog(1, 0, -1, 1'b0, nc);
    chk("jmp_count", {done, instr_count}, {1'b1, 4'd2});

    // PC wraps 63 -> 0, then BNZ forward to HALT.
    do_reset();
    fill_halt();
    imem[0] = enc(6, 2, 2);
    imem[1] = {3'd7, 6'd62};
    imem[62] = enc(3, 2, 1);
    imem[63] = enc(3, 2, 1);
    run_prog(1, 0, -1, 1'b0, nc);
    chk("wrap_count", instr_count, 5);

    for (int p = 0; p < 30; p++) begin
      if (p % 8 == 0) do_reset();
      gen_prog();
      run_prog(3, 3, -1, 1'($urandom_range(1, 0)), nc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
